// File: rtl/data_from_transfer_pkg.sv
// Shared constants and encodings for the word-to-byte unpacker on the transfer receive path.
package data_from_transfer_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int BYTE_W_DEF     = 8;
  localparam int BYTES_PER_WORD = WORD_W_DEF / BYTE_W_DEF;
  localparam int IDX_W          = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Same encoding as the byte-to-word collector so both ends agree on lane order.
  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } byte_order_t;

endpackage

// File: rtl/data_from_transfer_byte_lane_select.sv
// Combinational byte picker: held word plus emission index gives the byte to present.
module data_from_transfer_byte_lane_select
  import data_from_transfer_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int BYTE_W    = BYTE_W_DEF,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0] i_word,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [BYTE_W-1:0] o_byte
);

  localparam int                NB       = WORD_W / BYTE_W;
  localparam byte_order_t       ORDER    = LSB_FIRST ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB - 1);

  logic [BYTE_W-1:0] w_lanes [NB];
  logic [IDX_W-1:0]  w_lane;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_lanes[gi] = i_word[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // MSB-first walks the lanes from the top down.
  assign w_lane = (ORDER == ORDER_LSB_FIRST) ? i_idx : (LAST_IDX - i_idx);
  assign o_byte = w_lanes[w_lane];

endmodule

// File: rtl/data_from_transfer.sv
// Unpacks one word per handshake into a byte stream; no bubble between back-to-back words.
module data_from_transfer
  import data_from_transfer_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int BYTE_W    = BYTE_W_DEF,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] w_data_in,
  input  logic              w_valid_in,
  output logic              w_ready_out,
  output logic [BYTE_W-1:0] b_data_out,
  output logic              b_valid_out,
  input  logic              b_ready_in,
  output logic [IDX_W-1:0]  b_idx_out,
  output logic              b_last_out,
  output logic              busy_out
);

  localparam int               NB       = WORD_W / BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;

  logic w_at_last;
  logic w_word_hs;

  assign w_at_last = (r_idx == LAST_IDX);

  // Only combinational input-to-output path: the final byte being taken frees the holder.
  assign w_ready_out = !rst && ((r_state == IDLE) || (w_at_last && b_ready_in));
  assign w_word_hs   = w_valid_in && w_ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_word_hs) begin
            r_word  <= w_data_in;
            r_idx   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (b_ready_in) begin
            if (!w_at_last) begin
              r_idx <= r_idx + 1'b1;
            end else if (w_word_hs) begin
              r_word <= w_data_in;
              r_idx  <= '0;
            end else begin
              r_idx   <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  data_from_transfer_byte_lane_select #(
    .WORD_W    (WORD_W),
    .BYTE_W    (BYTE_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_lane_sel (
    .i_word (r_word),
    .i_idx  (r_idx),
    .o_byte (b_data_out)
  );

  assign b_valid_out = (r_state == SEND);
  assign busy_out    = (r_state == SEND);
  assign b_idx_out   = r_idx;
  assign b_last_out  = (r_state == SEND) && w_at_last;

endmodule

// File: tb/tb_data_from_transfer.sv
// Drives an LSB-first and an MSB-first unpacker with identical stimulus and scoreboards both byte streams.
module tb_data_from_transfer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] w_data_in;
  logic        w_valid_in;
  logic        b_ready_in;

  logic        l_w_ready, l_b_valid, l_b_last, l_busy;
  logic [7:0]  l_b_data;
  logic [1:0]  l_b_idx;
  logic        m_w_ready, m_b_valid, m_b_last, m_busy;
  logic [7:0]  m_b_data;
  logic [1:0]  m_b_idx;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t q_lsb[$];
  exp_t q_msb[$];

  int total = 0;
  int bad   = 0;
  int words_acc = 0;
  int bytes_popped = 0;

  always #5 clk = ~clk;

  data_from_transfer #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .w_data_in(w_data_in), .w_valid_in(w_valid_in),
    .w_ready_out(l_w_ready), .b_data_out(l_b_data), .b_valid_out(l_b_valid),
    .b_ready_in(b_ready_in), .b_idx_out(l_b_idx), .b_last_out(l_b_last), .busy_out(l_busy)
  );

  data_from_transfer #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .w_data_in(w_data_in), .w_valid_in(w_valid_in),
    .w_ready_out(m_w_ready), .b_data_out(m_b_data), .b_valid_out(m_b_valid),
    .b_ready_in(b_ready_in), .b_idx_out(m_b_idx), .b_last_out(m_b_last), .busy_out(m_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_byte(input string tag, input exp_t e, input logic [7:0] d,
                              input logic [1:0] i, input logic l);
    check({tag, "_data"}, 32'(d), 32'(e.data));
    check({tag, "_idx"},  32'(i), 32'(e.idx));
    check({tag, "_last"}, 32'(l), 32'(e.last));
  endtask

  // Evaluate handshakes a few ns before the edge, update scoreboards, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic [31:0] w;
    #2;
    if (rst) begin
      q_lsb.delete();
      q_msb.delete();
    end else begin
      check("ready_match", 32'(m_w_ready), 32'(l_w_ready));
      if (w_valid_in && l_w_ready) begin
        w = w_data_in;
        words_acc++;
        for (int k = 0; k < 4; k++) begin
          q_lsb.push_back('{data: w[k*8 +: 8],        idx: 2'(k), last: (k == 3)});
          q_msb.push_back('{data: w[(3-k)*8 +: 8],    idx: 2'(k), last: (k == 3)});
        end
      end
      if (l_b_valid && b_ready_in) begin
        if (q_lsb.size() == 0) check("lsb_extra_byte", 32'(l_b_valid), 32'd0);
        else begin
          e = q_lsb.pop_front();
          compare_byte("lsb", e, l_b_data, l_b_idx, l_b_last);
          bytes_popped++;
        end
      end
      if (m_b_valid && b_ready_in) begin
        if (q_msb.size() == 0) check("msb_extra_byte", 32'(m_b_valid), 32'd0);
        else begin
          e = q_msb.pop_front();
          compare_byte("msb", e, m_b_data, m_b_idx, m_b_last);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst        = 1'b1;
    w_data_in  = '0;
    w_valid_in = 1'b1;
    b_ready_in = 1'b1;
    @(posedge clk); #1;
    tick();
    tick();
    check("rst_b_valid", 32'(l_b_valid), 32'd0);
    check("rst_b_data",  32'(l_b_data),  32'd0);
    check("rst_b_idx",   32'(l_b_idx),   32'd0);
    check("rst_b_last",  32'(l_b_last),  32'd0);
    check("rst_busy",    32'(l_busy),    32'd0);
    check("rst_w_ready", 32'(l_w_ready), 32'd0);
    w_valid_in = 1'b0;
    rst = 1'b0;
    tick();

    // Single word, consumer always ready.
    w_data_in = 32'hA1B2C3D4; w_valid_in = 1'b1;
    tick();
    w_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("single_valid", 32'(l_b_valid), 32'd1);
      check("single_idx",   32'(l_b_idx),   32'(i));
      tick();
    end
    check("single_done_valid", 32'(l_b_valid), 32'd0);
    check("single_done_ready", 32'(l_w_ready), 32'd1);

    // Back-to-back words with no gap.
    w_data_in = 32'h03020100; w_valid_in = 1'b1;
    tick();
    w_data_in = 32'h07060504;
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid_a", 32'(l_b_valid), 32'd1);
      if (i == 3) check("b2b_ready_idx3", 32'(l_w_ready), 32'd1);
      else        check("b2b_ready_busy", 32'(l_w_ready), 32'd0);
      tick();
    end
    w_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid_b", 32'(l_b_valid), 32'd1);
      check("b2b_data_b",  32'(l_b_data),  32'(8'h04 + i));
      tick();
    end
    check("b2b_done_valid", 32'(l_b_valid), 32'd0);

    // Consumer stall on byte 1.
    w_data_in = 32'h11223344; w_valid_in = 1'b1;
    tick();
    w_valid_in = 1'b0;
    tick();
    b_ready_in = 1'b0;
    w_valid_in = 1'b1; w_data_in = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      check("stall_data",    32'(l_b_data),  32'h33);
      check("stall_idx",     32'(l_b_idx),   32'd1);
      check("stall_w_ready", 32'(l_w_ready), 32'd0);
      check("stall_msb_data", 32'(m_b_data), 32'h22);
      tick();
    end
    w_valid_in = 1'b0; b_ready_in = 1'b1;
    tick();
    check("stall_resume", 32'(l_b_data), 32'h22);
    tick();
    tick();
    check("stall_done_valid", 32'(l_b_valid), 32'd0);

    // Reset in the middle of a word.
    w_data_in = 32'hA1B2C3D4; w_valid_in = 1'b1;
    tick();
    w_valid_in = 1'b0;
    tick();
    check("midrst_pre_data", 32'(l_b_data), 32'hC3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(l_b_valid), 32'd0);
    check("midrst_idx",   32'(l_b_idx),   32'd0);
    check("midrst_busy",  32'(l_busy),    32'd0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_quiet", 32'(l_b_valid), 32'd0);
      tick();
    end

    // Randomised valid/ready over many words.
    words_acc = 0;
    bytes_popped = 0;
    cyc = 0;
    while (cyc < 20000 && (words_acc < 1000 || q_lsb.size() != 0)) begin
      w_valid_in = (words_acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      w_data_in  = $urandom;
      b_ready_in = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("rand_words",   32'(words_acc),    32'd1000);
    check("rand_bytes",   32'(bytes_popped), 32'd4000);
    check("rand_q_empty", 32'(q_lsb.size()), 32'd0);
    check("rand_msb_q_empty", 32'(q_msb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
